// File: rtl/ghrd_pio_bank.sv
// ghrd_pio_bank: Avalon-MM PIO bank for the GHRD lightweight H2F bridge.
// Debounced board inputs with W1C edge capture and maskable level IRQ,
// plus an output register with atomic set/clear aliases.

// Per-channel 2-flop synchroniser followed by a stable-count debouncer.
module ghrd_pio_deb #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic deb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta, sync;
  logic [CW-1:0] cnt;

  // Synchronise the pin, then accept a new level only after it has differed
  // from deb for DEBOUNCE_CYCLES consecutive clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      deb  <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      if (sync == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module ghrd_pio_bank #(
  parameter int                 NUM_IN          = 4,
  parameter int                 NUM_OUT         = 4,
  parameter int                 DEBOUNCE_CYCLES = 50000,
  parameter logic [NUM_OUT-1:0] OUT_RESET       = '0
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [2:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic               irq,
  input  logic [NUM_IN-1:0]  gpio_in,
  output logic [NUM_OUT-1:0] gpio_out
);
  localparam logic [2:0] A_DATA_IN  = 3'd0;
  localparam logic [2:0] A_DATA_OUT = 3'd1;
  localparam logic [2:0] A_OUT_SET  = 3'd2;
  localparam logic [2:0] A_OUT_CLR  = 3'd3;
  localparam logic [2:0] A_IRQ_MASK = 3'd4;
  localparam logic [2:0] A_EDGE_CAP = 3'd5;
  localparam logic [2:0] A_RISE_EN  = 3'd6;
  localparam logic [2:0] A_FALL_EN  = 3'd7;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } avs_req_t;

  avs_req_t           req;
  logic [7:0]         wsel;
  logic [NUM_IN-1:0]  wd_in;
  logic [NUM_OUT-1:0] wd_out;
  logic               unused_wdata;

  logic [NUM_IN-1:0]  deb, deb_q;
  logic [NUM_IN-1:0]  irq_mask, edge_cap, rise_en, fall_en;
  logic [NUM_IN-1:0]  cap_nxt, w1c;
  logic [NUM_OUT-1:0] data_out;
  logic [31:0]        rd_mux;

  assign req    = '{rd: avs_read, wr: avs_write, addr: avs_address, wdata: avs_writedata};
  assign wsel   = req.wr ? (8'd1 << req.addr) : 8'd0;
  assign wd_in  = req.wdata[NUM_IN-1:0];
  assign wd_out = req.wdata[NUM_OUT-1:0];
  // Upper write-data bits beyond the channel count are simply dropped.
  assign unused_wdata = ^req.wdata;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
      ghrd_pio_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .pin   (gpio_in[gi]),
        .deb   (deb[gi])
      );
    end
  endgenerate

  // Output register: direct write plus atomic set/clear aliases.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_out <= OUT_RESET;
    end else if (wsel[A_DATA_OUT]) begin
      data_out <= wd_out;
    end else if (wsel[A_OUT_SET]) begin
      data_out <= data_out | wd_out;
    end else if (wsel[A_OUT_CLR]) begin
      data_out <= data_out & ~wd_out;
    end
  end

  assign gpio_out = data_out;

  // Plain RW control registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_mask <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else begin
      if (wsel[A_IRQ_MASK]) irq_mask <= wd_in;
      if (wsel[A_RISE_EN])  rise_en  <= wd_in;
      if (wsel[A_FALL_EN])  fall_en  <= wd_in;
    end
  end

  // Edge detect against last cycle's debounced level; a new edge beats a W1C.
  always_comb begin
    w1c     = wsel[A_EDGE_CAP] ? wd_in : '0;
    cap_nxt = (edge_cap & ~w1c)
            | (deb & ~deb_q & rise_en)
            | (~deb & deb_q & fall_en);
  end

  // Capture register and the registered level IRQ it drives.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      deb_q    <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      deb_q    <= deb;
      edge_cap <= cap_nxt;
      irq      <= |(edge_cap & irq_mask);
    end
  end

  // Read mux sees pre-write state, so a same-cycle write/read returns old data.
  always_comb begin
    rd_mux = '0;
    case (req.addr)
      A_DATA_IN:  rd_mux = 32'(deb);
      A_DATA_OUT: rd_mux = 32'(data_out);
      A_IRQ_MASK: rd_mux = 32'(irq_mask);
      A_EDGE_CAP: rd_mux = 32'(edge_cap);
      A_RISE_EN:  rd_mux = 32'(rise_en);
      A_FALL_EN:  rd_mux = 32'(fall_en);
      default:    rd_mux = '0;
    endcase
  end

  // One-cycle read latency; data holds between reads.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (req.rd) begin
      avs_readdata <= rd_mux;
    end
  end
endmodule
